// File: rtl/shift32_pkg.sv
// Shared constants and helpers for the 32-bit registered logical shifter.
package shift32_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Mirrors a word so that a right shift of the mirror acts as a left shift.
  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift32_reg_if.sv
// Operand/result bundle between the ALU shift unit and its driver.
interface shift32_reg_if;

  logic [shift32_pkg::WIDTH-1:0] D;
  logic [shift32_pkg::WIDTH-1:0] S;
  logic                          LnR;
  logic [shift32_pkg::WIDTH-1:0] Y;

  modport master (output D, output S, output LnR, input Y);
  modport slave  (input D, input S, input LnR, output Y);

endinterface

// File: rtl/shift32_rshift_core.sv
// Combinational logical right barrel shifter: one 2:1 mux stage per shift-amount bit.
module shift32_rshift_core
  import shift32_pkg::*;
(
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   data_o
);

  logic [WIDTH-1:0] stage [SHAMT_W+1];

  assign stage[0] = data_i;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int DIST = 1 << k;
    logic [WIDTH-1:0] shifted;
    assign shifted      = {{DIST{1'b0}}, stage[k][WIDTH-1:DIST]};
    assign stage[k + 1] = shamt_i[k] ? shifted : stage[k];
  end

  assign data_o = stage[SHAMT_W];

endmodule

// File: rtl/shift32_reg.sv
// 32-bit logical left/right shifter with zero fill and a single output register (1-cycle latency).
module shift32_reg
  import shift32_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  shift32_reg_if.slave  bus
);

  logic [WIDTH-1:0] core_in;
  logic [WIDTH-1:0] core_out;
  logic             ovf;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  // Left shifts reuse the right shifter by mirroring data on the way in and out.
  assign core_in = (bus.LnR == DIR_LEFT) ? bit_rev(bus.D) : bus.D;

  shift32_rshift_core u_core (
    .data_i  (core_in),
    .shamt_i (bus.S[SHAMT_W-1:0]),
    .data_o  (core_out)
  );

  assign ovf = |bus.S[WIDTH-1:SHAMT_W];

  always_comb begin
    y_d = (bus.LnR == DIR_LEFT) ? bit_rev(core_out) : core_out;
    if (ovf) begin
      y_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign bus.Y = y_q;

endmodule

// File: tb/tb_shift32_reg.sv
// Self-checking bench for shift32_reg: directed corner cases plus randomized traffic vs. an arithmetic model.
module tb_shift32_reg;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  shift32_reg_if bus ();

  shift32_reg dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] s,
                                            input logic lnr);
    if (s >= 32) return 32'h0;
    return lnr ? (d << s) : (d >> s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one operation away from the active edge, then check Y just after the edge.
  task automatic apply(input string tag, input logic rst_v, input logic [31:0] d,
                       input logic [31:0] s, input logic lnr);
    logic [31:0] exp;
    @(negedge CLK);
    RST     = rst_v;
    bus.D   = d;
    bus.S   = s;
    bus.LnR = lnr;
    exp     = rst_v ? ref_shift(d, s, lnr) : 32'h0;
    @(posedge CLK);
    #1;
    check(tag, bus.Y, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rs;
    logic        rl;
    logic        rr;
    n_checks = 0;
    n_errors = 0;
    RST      = 1'b0;
    bus.D    = 32'hFFFF_FFFF;
    bus.S    = 32'h0;
    bus.LnR  = 1'b0;

    apply("reset_0", 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    apply("reset_1", 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Directed cases, back to back with no idle cycles.
    apply("max_right",   1'b1, 32'hFFFF_FFFF, 32'd31, 1'b0);
    check("max_right_c", bus.Y, 32'h0000_0001);
    apply("max_left",    1'b1, 32'hFFFF_FFFF, 32'd31, 1'b1);
    check("max_left_c",  bus.Y, 32'h8000_0000);
    apply("nib_left",    1'b1, 32'h1234_5678, 32'd4, 1'b1);
    check("nib_left_c",  bus.Y, 32'h2345_6780);
    apply("nib_right",   1'b1, 32'h1234_5678, 32'd4, 1'b0);
    check("nib_right_c", bus.Y, 32'h0123_4567);
    apply("no_sext",     1'b1, 32'h8000_0000, 32'd1, 1'b0);
    check("no_sext_c",   bus.Y, 32'h4000_0000);
    apply("s0_right",    1'b1, 32'hA5A5_A5A5, 32'd0, 1'b0);
    check("s0_right_c",  bus.Y, 32'hA5A5_A5A5);
    apply("s0_left",     1'b1, 32'hA5A5_A5A5, 32'd0, 1'b1);
    check("s0_left_c",   bus.Y, 32'hA5A5_A5A5);
    apply("ovf32_r",     1'b1, 32'hFFFF_FFFF, 32'd32, 1'b0);
    apply("ovf32_l",     1'b1, 32'hFFFF_FFFF, 32'd32, 1'b1);
    apply("ovf_hi_r",    1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    apply("ovf_hi_l",    1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
    check("ovf_hi_l_c",  bus.Y, 32'h0000_0000);
    apply("single_bit",  1'b1, 32'h0000_0001, 32'd17, 1'b1);
    check("single_bit_c", bus.Y, 32'h0002_0000);

    // Reset dropped mid-stream, then released.
    apply("mid_reset",   1'b0, 32'hDEAD_BEEF, 32'd3, 1'b1);
    apply("post_reset",  1'b1, 32'hDEAD_BEEF, 32'd3, 1'b1);
    check("post_reset_c", bus.Y, 32'hF56D_F778);

    // Randomized traffic: in-range, near-overflow and full-range amounts, occasional reset.
    for (int i = 0; i < 400; i++) begin
      rd = $urandom;
      rl = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1:    rs = 32'($urandom_range(0, 31));
        2:       rs = 32'($urandom_range(32, 40));
        default: rs = $urandom;
      endcase
      rr = ($urandom_range(0, 19) != 0);
      apply("random", rr, rd, rs, rl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift32_reg.md
Name: shift32_reg

Overview:
- 32-bit logical barrel shifter with a registered output, for the datapath ALU shift unit.
- Shifts data word D left or right by amount S, with zero fill.
- Result is captured on the clock edge, giving a fixed 1-cycle latency.
- Shift core is purely combinational; one output register follows it.

Parameters:
- WIDTH, 32, data width. Only 32 is required to be supported.
- SHAMT_W, 5, number of shift-amount bits used by the mux stages. Equals log2(WIDTH).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-low reset.
- D    input  32  data to shift.
- S    input  32  shift amount, unsigned.
- LnR  input  1  direction: 1 = shift left, 0 = shift right (logical).
- Y    output 32  registered shift result.

Interface (already decided): one clock; reset is synchronous and active-low.

Behaviour:
- At every rising CLK edge with RST=0: Y <= 0.
- At every rising CLK edge with RST=1: Y <= shift(D, S, LnR). D, S and LnR are sampled at that same edge.
- Latency: exactly 1 cycle. No handshake; a new operation is accepted every cycle.
- Left shift (LnR=1): Y = D << S. Vacated LSBs are filled with 0.
- Right shift (LnR=0): logical Y = D >> S. Vacated MSBs are filled with 0; there is no sign extension.
- S is a full 32-bit unsigned value:
  - If any of S[31:5] is 1 (S >= 32), the result is 0x00000000 for both directions.
  - Otherwise the shift amount is S[4:0].
- S=0 passes D through unchanged in both directions.
- S=31:
  - Left: result = {D[0], 31'b0}.
  - Right: result = {31'b0, D[31]}.
- Shift core structure:
  - 5 cascaded 2:1 mux stages with shift distances 1, 2, 4, 8, 16, each controlled by one bit S[0]..S[4].
  - Left shift is done by bit-reversing D, right-shifting, then bit-reversing the result.
  - A final mux forces 0 when S[31:5] is non-zero.
- Reset asserted mid-stream: Y is 0 from the first edge that samples RST=0.
- After reset is released, the first valid Y appears 1 edge after RST=1 is sampled, reflecting the inputs at that edge.
- No X propagation when inputs are known; no internal state other than the Y register.

Decomposition:
- Package shift32_pkg: WIDTH=32, SHAMT_W=5, and the direction encoding constants DIR_LEFT=1'b1 and DIR_RIGHT=1'b0.
- Sub-module shift32_rshift_core: combinational 32-bit logical right barrel shifter built from the 5 mux stages.
  - Inputs: data and the 5-bit shift amount.
- Top shift32_reg contains:
  - the bit-reversal wrapping for left shifts,
  - the overflow zeroing for S >= 32,
  - the output register.

Test Plan:
- Reset: drive RST=0 with D=0xFFFFFFFF, S=0 for 2 edges -> Y=0x00000000.
- Max-shift right: D=0xFFFFFFFF, LnR=0, S=31 -> Y=0x00000001 one edge later.
- Max-shift left: same D, LnR=1, S=31 -> Y=0x80000000.
- Nibble shifts, D=0x12345678, S=4:
  - LnR=1 -> Y=0x23456780.
  - LnR=0 -> Y=0x01234567.
- Logical fill and S=0:
  - D=0x80000000, LnR=0, S=1 -> Y=0x40000000 (no sign extension).
  - D=0xA5A5A5A5, S=0, either LnR -> Y=0xA5A5A5A5.
- Overflow amounts, D=0xFFFFFFFF, LnR=0 and LnR=1:
  - S=32 -> Y=0x00000000.
  - S=0x80000001 -> Y=0x00000000.
- Back-to-back: change inputs every cycle across the cases above -> each Y matches the previous cycle's inputs, with no bubbles.
